// File: rtl/noc_pkg.sv
// Shared definitions for the router input-port slice: port indices,
// port count and the input-port controller state encoding.
package noc_pkg;

    localparam int N_PORTS = 5;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    typedef enum logic [2:0] {
        IDLE,
        HEAD,
        ROUTE,
        REQ,
        SEND_HDR,
        SEND_BODY
    } state_t;

endpackage

// File: rtl/xy_route_compute.sv
// XY dimension-ordered route decision: picks the output port from the signed
// hop offsets and steps the offset of the travelled dimension toward zero.
module xy_route_compute
    import noc_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]  i_hdr,
    output logic [ADDR_W-1:0]  o_hdr,
    output logic [2:0]         o_port,
    output logic [N_PORTS-1:0] o_req
);

    localparam int HALF_W = ADDR_W / 2;
    localparam logic signed [HALF_W-1:0] ONE = {{(HALF_W-1){1'b0}}, 1'b1};

    logic signed [HALF_W-1:0] w_dx;
    logic signed [HALF_W-1:0] w_dy;
    logic signed [HALF_W-1:0] w_dx_nxt;
    logic signed [HALF_W-1:0] w_dy_nxt;

    assign w_dx = i_hdr[HALF_W-1:0];
    assign w_dy = i_hdr[ADDR_W-1:HALF_W];

    // X is always resolved before Y; a zero offset pair means the packet has arrived
    always_comb begin
        w_dx_nxt = w_dx;
        w_dy_nxt = w_dy;
        o_port   = PORT_LOCAL;
        o_req    = '0;
        if (w_dx != '0 && !w_dx[HALF_W-1]) begin
            o_port   = PORT_EAST;
            w_dx_nxt = w_dx - ONE;
            o_req[3] = 1'b1;
        end else if (w_dx[HALF_W-1]) begin
            o_port   = PORT_WEST;
            w_dx_nxt = w_dx + ONE;
            o_req[4] = 1'b1;
        end else if (w_dy != '0 && !w_dy[HALF_W-1]) begin
            o_port   = PORT_NORTH;
            w_dy_nxt = w_dy - ONE;
            o_req[1] = 1'b1;
        end else if (w_dy[HALF_W-1]) begin
            o_port   = PORT_SOUTH;
            w_dy_nxt = w_dy + ONE;
            o_req[2] = 1'b1;
        end else begin
            o_req[0] = 1'b1;
        end
    end

    assign o_hdr = {w_dy_nxt, w_dx_nxt};

endmodule

// File: rtl/noc_input_port.sv
// Router input-port controller: collects a multi-flit header from the FWFT
// FIFO, routes it XY, arbitrates, then forwards rewritten header and payload.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int FLIT_W       = 4,
    parameter int ADDR_W       = 16,
    parameter int PACKET_FLITS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    input  logic [FLIT_W-1:0]  flit_in,
    output logic               read_fifo,
    input  logic               grant,
    input  logic [N_PORTS-1:0] dest_full,
    output logic [N_PORTS-1:0] request,
    output logic [2:0]         dest_port,
    output logic [FLIT_W-1:0]  flit_out,
    output logic               flit_out_valid,
    output logic               packet_done
);

    localparam int HDR_FLITS = ADDR_W / FLIT_W;
    localparam int CNT_W     = $clog2(PACKET_FLITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_FLITS - 1);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PACKET_FLITS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_hdr;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_dest_port;
    logic [N_PORTS-1:0] r_req;

    logic [ADDR_W-1:0]  w_hdr_new;
    logic [2:0]         w_port;
    logic [N_PORTS-1:0] w_req;
    logic               w_xfer;
    logic               w_body_xfer;

    xy_route_compute #(
        .ADDR_W (ADDR_W)
    ) u_route (
        .i_hdr  (r_hdr),
        .o_hdr  (w_hdr_new),
        .o_port (w_port),
        .o_req  (w_req)
    );

    assign w_xfer      = grant & ~dest_full[r_dest_port];
    assign w_body_xfer = w_xfer & ~fifo_empty;
    assign dest_port   = r_dest_port;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        read_fifo      = 1'b0;
        flit_out_valid = 1'b0;
        flit_out       = '0;
        request        = '0;
        packet_done    = 1'b0;
        case (r_state)
            IDLE: begin
                read_fifo = ~fifo_empty;
                if (!fifo_empty) w_state_nxt = HEAD;
            end
            HEAD: begin
                read_fifo = ~fifo_empty;
                if (!fifo_empty && r_cnt == HDR_LAST) w_state_nxt = ROUTE;
            end
            ROUTE: begin
                // arbiter sees the fresh route before it is registered
                request     = w_req;
                w_state_nxt = grant ? SEND_HDR : REQ;
            end
            REQ: begin
                request = r_req;
                if (grant) w_state_nxt = SEND_HDR;
            end
            SEND_HDR: begin
                request        = r_req;
                flit_out       = r_hdr[FLIT_W-1:0];
                flit_out_valid = w_xfer;
                if (w_xfer && r_cnt == HDR_LAST) w_state_nxt = SEND_BODY;
            end
            SEND_BODY: begin
                request        = r_req;
                flit_out       = flit_in;
                flit_out_valid = w_body_xfer;
                read_fifo      = w_body_xfer;
                if (w_body_xfer && r_cnt == PKT_LAST) begin
                    packet_done = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // IDLE pops combinationally, so keep the FIFO untouched while reset is held
        if (reset) read_fifo = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hdr       <= '0;
            r_cnt       <= '0;
            r_dest_port <= '0;
            r_req       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!fifo_empty) begin
                        r_hdr <= {flit_in, r_hdr[ADDR_W-1:FLIT_W]};
                        r_cnt <= CNT_ONE;
                    end
                end
                HEAD: begin
                    if (!fifo_empty) begin
                        r_hdr <= {flit_in, r_hdr[ADDR_W-1:FLIT_W]};
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ROUTE: begin
                    r_hdr       <= w_hdr_new;
                    r_dest_port <= w_port;
                    r_req       <= w_req;
                    r_cnt       <= '0;
                end
                SEND_HDR: begin
                    if (w_xfer) begin
                        r_hdr <= {{FLIT_W{1'b0}}, r_hdr[ADDR_W-1:FLIT_W]};
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                SEND_BODY: begin
                    if (w_body_xfer) begin
                        if (r_cnt == PKT_LAST) begin
                            r_cnt <= '0;
                            r_req <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_input_port.sv
// Randomised bench for noc_input_port: a queue-based FIFO source and an
// arithmetic XY reference model predict every forwarded flit and request.
module tb_noc_input_port;
    import noc_pkg::*;

    localparam int FLIT_W       = 4;
    localparam int ADDR_W       = 16;
    localparam int PACKET_FLITS = 8;
    localparam int HDR_FLITS    = ADDR_W / FLIT_W;
    localparam int HALF         = ADDR_W / 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               fifo_empty;
    logic [FLIT_W-1:0]  flit_in;
    logic               read_fifo;
    logic               grant;
    logic [N_PORTS-1:0] dest_full;
    logic [N_PORTS-1:0] request;
    logic [2:0]         dest_port;
    logic [FLIT_W-1:0]  flit_out;
    logic               flit_out_valid;
    logic               packet_done;

    always #5 clk = ~clk;

    noc_input_port #(
        .FLIT_W       (FLIT_W),
        .ADDR_W       (ADDR_W),
        .PACKET_FLITS (PACKET_FLITS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fifo_empty     (fifo_empty),
        .flit_in        (flit_in),
        .read_fifo      (read_fifo),
        .grant          (grant),
        .dest_full      (dest_full),
        .request        (request),
        .dest_port      (dest_port),
        .flit_out       (flit_out),
        .flit_out_valid (flit_out_valid),
        .packet_done    (packet_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [FLIT_W-1:0] src_q[$];
    logic [FLIT_W-1:0] exp_q[$];
    bit                exp_last_q[$];
    int                port_q[$];

    int mode;
    bit hold_empty;
    bit do_pop;
    bit prev_done;
    int out_idx;
    int req_wait;
    int g_phase;
    int full_left;
    int empty_left;
    bit full_armed;
    bit empty_armed;
    logic [N_PORTS-1:0] prev_req;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference XY routing from plain integer arithmetic on the offsets
    task automatic ref_route(input logic [ADDR_W-1:0] h, output int port,
                             output logic [ADDR_W-1:0] nh);
        int dx;
        int dy;
        dx = int'($signed(h[HALF-1:0]));
        dy = int'($signed(h[ADDR_W-1:HALF]));
        if (dx > 0) begin
            port = 3; dx = dx - 1;
        end else if (dx < 0) begin
            port = 4; dx = dx + 1;
        end else if (dy > 0) begin
            port = 1; dy = dy - 1;
        end else if (dy < 0) begin
            port = 2; dy = dy + 1;
        end else begin
            port = 0;
        end
        nh = {dy[HALF-1:0], dx[HALF-1:0]};
    endtask

    task automatic push_packet(input logic [ADDR_W-1:0] h, input logic [FLIT_W-1:0] base);
        int port;
        logic [ADDR_W-1:0] nh;
        logic [FLIT_W-1:0] f;
        ref_route(h, port, nh);
        for (int k = 0; k < HDR_FLITS; k++) begin
            src_q.push_back(h[k*FLIT_W +: FLIT_W]);
            exp_q.push_back(nh[k*FLIT_W +: FLIT_W]);
            exp_last_q.push_back(1'b0);
        end
        f = base;
        for (int k = HDR_FLITS; k < PACKET_FLITS; k++) begin
            src_q.push_back(f);
            exp_q.push_back(f);
            exp_last_q.push_back(k == PACKET_FLITS - 1);
            f = f + 1'b1;
        end
        port_q.push_back(port);
    endtask

    task automatic apply_fifo();
        fifo_empty = (src_q.size() == 0) || hold_empty;
        flit_in    = (src_q.size() > 0) ? src_q[0] : '0;
    endtask

    task automatic sample();
        if (reset) return;
        if (prev_done) check("req_clear_after_tail", request, 0);
        prev_done = packet_done;
        do_pop    = read_fifo;
        if (read_fifo) check("pop_while_empty", fifo_empty, 0);
        if (request != 0 && port_q.size() > 0)
            check("request_onehot", request, 32'(1) << port_q[0]);
        if (flit_out_valid) begin
            check("flit_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check("flit_out", flit_out, exp_q[0]);
                check("packet_done", packet_done, exp_last_q[0]);
                check("dest_port", dest_port, port_q[0]);
                check("xfer_allowed", grant & ~dest_full[dest_port], 1);
                out_idx++;
                if (exp_last_q[0]) begin
                    void'(port_q.pop_front());
                    out_idx = 0;
                end
                void'(exp_q.pop_front());
                void'(exp_last_q.pop_front());
            end
        end else if (packet_done) begin
            check("done_without_flit", packet_done, 0);
        end
        if (mode == 2) begin
            if (g_phase == 0 && request != 0 && !grant) begin
                req_wait++;
                check("wait_no_activity", {read_fifo, flit_out_valid}, 0);
                if (req_wait > 1) check("req_stable", request, prev_req);
            end else if (g_phase == 1) begin
                check("grant_cycle_no_flit", flit_out_valid, 0);
                g_phase = 2;
            end else if (g_phase == 2) begin
                check("first_hdr_after_grant", flit_out_valid, 1);
                g_phase = 3;
            end
        end
        if (mode == 3) begin
            if (dest_full[3]) check("full_stall", {read_fifo, flit_out_valid}, 0);
            if (out_idx == HDR_FLITS + 1 && !full_armed) begin
                full_armed = 1'b1;
                full_left  = 3;
            end
            if (out_idx == HDR_FLITS + 2 && !empty_armed) begin
                empty_armed = 1'b1;
                empty_left  = 2;
            end
        end
        prev_req = request;
    endtask

    task automatic update();
        if (do_pop && src_q.size() > 0) void'(src_q.pop_front());
        do_pop = 1'b0;
        case (mode)
            1: begin
                grant      = ($urandom_range(9) < 7);
                dest_full  = 5'($urandom) & 5'($urandom) & 5'($urandom);
                hold_empty = ($urandom_range(4) == 0);
            end
            2: begin
                dest_full  = '0;
                hold_empty = 1'b0;
                grant      = (req_wait >= 6);
                if (grant && g_phase == 0) g_phase = 1;
            end
            3: begin
                grant        = 1'b1;
                dest_full    = '0;
                dest_full[3] = (full_left > 0);
                hold_empty   = (empty_left > 0);
                if (full_left > 0) full_left--;
                if (empty_left > 0) empty_left--;
            end
            default: begin
                grant      = 1'b1;
                dest_full  = '0;
                hold_empty = 1'b0;
            end
        endcase
        apply_fifo();
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        update();
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((exp_q.size() > 0 || src_q.size() > 0) && n < max_cycles) begin
            step();
            n++;
        end
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        grant      = 1'b0;
        dest_full  = '0;
        hold_empty = 1'b0;
        do_pop     = 1'b0;
        prev_done  = 1'b0;
        out_idx    = 0;
        mode       = 0;
        req_wait   = 0;
        g_phase    = 0;
        full_left  = 0;
        empty_left = 0;
        full_armed = 1'b0;
        empty_armed = 1'b0;
        prev_req   = '0;
        apply_fifo();
        repeat (2) @(posedge clk);
        #1;
        check("rst_read_fifo", read_fifo, 0);
        check("rst_valid", flit_out_valid, 0);
        check("rst_request", request, 0);
        check("rst_dest_port", dest_port, 0);
        check("rst_flit_out", flit_out, 0);
        check("rst_packet_done", packet_done, 0);
        reset = 1'b0;
        update();

        // directed routes, back to back, grant held
        mode = 0;
        push_packet(16'h0203, 4'hA);
        push_packet(16'h00FE, 4'h1);
        push_packet(16'h0100, 4'h5);
        push_packet(16'h0000, 4'h9);
        drain(2000);

        // grant withheld after route
        mode = 2;
        push_packet(16'hFD00, 4'h3);
        drain(500);
        check("grant_withhold_seen", g_phase, 3);

        // downstream full on B, FIFO empty on C
        mode = 3;
        push_packet(16'h0203, 4'hA);
        drain(500);
        check("stall_windows_seen", {full_armed, empty_armed}, 2'b11);

        // randomised traffic
        mode = 1;
        for (int i = 0; i < 40; i++) push_packet(16'($urandom), 4'($urandom));
        drain(20000);

        // reset in the middle of the payload
        mode = 0;
        push_packet(16'h0203, 4'hA);
        n = 0;
        while (out_idx != HDR_FLITS + 1 && n < 200) begin
            step();
            n++;
        end
        check("reached_body", out_idx, HDR_FLITS + 1);
        reset = 1'b1;
        #1;
        check("mid_rst_read_fifo", read_fifo, 0);
        check("mid_rst_valid", flit_out_valid, 0);
        check("mid_rst_request", request, 0);
        check("mid_rst_dest_port", dest_port, 0);
        check("mid_rst_flit_out", flit_out, 0);
        check("mid_rst_packet_done", packet_done, 0);
        src_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        port_q.delete();
        out_idx   = 0;
        prev_done = 1'b0;
        do_pop    = 1'b0;
        apply_fifo();
        @(posedge clk);
        #1;
        reset = 1'b0;
        push_packet(16'h00FE, 4'h2);
        apply_fifo();
        drain(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
